// File: rtl/cblock_cfg_loader.sv
// Configuration loader for a chain of connection blocks on one shared bus.
// It takes a serial bitstream over a valid/ready handshake and packs it into
// WORD_W-bit words, MSB first. Each finished word is written into the next
// block by a one-cycle, one-hot wr_en pulse. Blocks are loaded in index order.
module cblock_cfg_loader #(
  parameter int NUM_BLOCKS = 4,
  parameter int WORD_W     = 18,
  parameter int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cfg_valid,
  input  logic                  cfg_data,
  output logic                  cfg_ready,
  output logic [NUM_BLOCKS-1:0] wr_en,
  output logic [WORD_W-1:0]     bits,
  output logic [IDX_W-1:0]      blk_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] LAST_BLK = IDX_W'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] next_word;

  // The word as it will look once the bit on cfg_data is shifted in.
  assign next_word = {shreg[WORD_W-2:0], cfg_data};

  // The loader only takes bits while it is assembling a word.
  assign cfg_ready = (state == SHIFT);

  // Load sequencer: abort beats everything except reset, and the write strobe
  // is set up on the edge that accepts the final bit, so it lives for exactly
  // the WRITE cycle while bits already holds the finished word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      wr_en   <= '0;
      bits    <= '0;
      blk_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      wr_en   <= '0;
      blk_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wr_en <= '0;
          if (start) begin
            state   <= SHIFT;
            shreg   <= '0;
            bit_cnt <= '0;
            blk_idx <= '0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (cfg_valid) begin
            shreg <= next_word;
            if (bit_cnt == LAST_BIT) begin
              bits    <= next_word;
              bit_cnt <= '0;
              wr_en   <= NUM_BLOCKS'(1) << blk_idx;
              state   <= WRITE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          wr_en <= '0;
          if (blk_idx == LAST_BLK) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            blk_idx <= blk_idx + IDX_W'(1);
            state   <= SHIFT;
          end
        end
        DONE: begin
          wr_en <= '0;
          if (start) begin
            state   <= SHIFT;
            shreg   <= '0;
            bit_cnt <= '0;
            blk_idx <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          wr_en <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cblock_cfg_loader.sv
// Scoreboard bench for cblock_cfg_loader. Stimulus pushes each expected block
// write into a queue; a monitor on the falling edge pops and compares whenever
// wr_en is active. Inputs change 1 time unit after the rising edge.
module tb_cblock_cfg_loader;

  localparam int NB = 4;
  localparam int WW = 18;
  localparam int IW = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          cfg_valid;
  logic          cfg_data;
  logic          cfg_ready;
  logic [NB-1:0] wr_en;
  logic [WW-1:0] bits;
  logic [IW-1:0] blk_idx;
  logic          busy;
  logic          done;

  typedef struct {
    int            blk;
    logic [WW-1:0] word;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic [NB-1:0] prev_wr = '0;

  cblock_cfg_loader #(.NUM_BLOCKS(NB), .WORD_W(WW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .wr_en(wr_en), .bits(bits), .blk_idx(blk_idx), .busy(busy), .done(done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time wr_en pulses and done against the start edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every active wr_en is matched against the next queued write.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en != '0) begin
        check_output("wr_pulse_width", int'(prev_wr), 0);
        if (q.size() == 0) begin
          check_output("unexpected_wr_en", int'(wr_en), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_output("wr_en_onehot", int'(wr_en), 1 << e.blk);
          check_output("wr_bits", int'(bits), int'(e.word));
          if (e.cyc >= 0) check_output("wr_cycle", cyc, e.cyc);
        end
      end
      prev_wr = wr_en;
    end else begin
      prev_wr = '0;
    end
  end

  // One full or aborted load. timing: cfg_valid held high, so write and done
  // cycles are fixed; extra_start pulses start mid block 2; do_abort aborts
  // after 10 bits of block 1.
  task automatic apply_stimulus(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                                input logic [WW-1:0] w2, input logic [WW-1:0] w3,
                                input bit toggle, input bit extra_start, input bit do_abort);
    logic [WW-1:0] w [NB];
    int  t0;
    int  ptr;
    int  limit;
    int  c;
    bit  acc;
    bit  seen_done;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    limit = do_abort ? (WW + 10) : (NB * WW);
    @(posedge clk); #1;
    start = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
    t0 = cyc;
    for (int k = 0; k < NB; k++) begin
      if (!do_abort || k == 0) q.push_back('{k, w[k], toggle ? -1 : t0 + 19 * (k + 1)});
    end
    acc = 1'b0; ptr = 0; c = 0;
    while (ptr < limit && c < 600) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 0) begin
        check_output("start_done_low", int'(done), 0);
        check_output("start_busy_high", int'(busy), 1);
        check_output("start_blk_idx", int'(blk_idx), 0);
      end
      if (acc) ptr++;
      if (ptr < limit) begin
        cfg_valid = toggle ? ((c % 2) == 0) : 1'b1;
        cfg_data  = w[ptr / WW][WW - 1 - (ptr % WW)];
        if (extra_start && ptr == 2 * WW + 5) start = 1'b1;
        acc = cfg_valid && cfg_ready;
      end
      c++;
    end
    if (ptr < limit) check_output("stream_timeout", ptr, limit);
    cfg_valid = 1'b0;
    if (do_abort) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check_output("abort_cfg_ready", int'(cfg_ready), 0);
      check_output("abort_wr_en", int'(wr_en), 0);
      check_output("abort_blk_idx", int'(blk_idx), 0);
      check_output("abort_done", int'(done), 0);
      check_output("abort_busy", int'(busy), 0);
    end else begin
      seen_done = 1'b0;
      for (int i = 0; i < 60 && !seen_done; i++) begin
        if (done) begin
          seen_done = 1'b1;
          if (!toggle) check_output("done_cycle", cyc, t0 + 19 * NB + 1);
          check_output("done_busy_low", int'(busy), 0);
        end else begin
          @(posedge clk); #1;
        end
      end
      if (!seen_done) check_output("done_timeout", 0, 1);
      check_output("queue_drained", q.size(), 0);
    end
  endtask

  // Directed sequence of loads, abort and mid-write reset.
  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
    #12;
    check_output("rst_wr_en", int'(wr_en), 0);
    check_output("rst_bits", int'(bits), 0);
    check_output("rst_blk_idx", int'(blk_idx), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_cfg_ready", int'(cfg_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_output("idle_cfg_ready", int'(cfg_ready), 0);

    $display("[TB] load with cfg_valid held high");
    apply_stimulus(18'h3FFFF, 18'h00000, 18'h2AAAA, 18'h15555, 1'b0, 1'b0, 1'b0);
    check_output("bits_hold_last", int'(bits), 18'h15555);

    $display("[TB] restart from DONE");
    apply_stimulus(18'h12345, 18'h0F0F0, 18'h30C30, 18'h00001, 1'b0, 1'b0, 1'b0);

    $display("[TB] load with cfg_valid toggling");
    apply_stimulus(18'h3FFFF, 18'h00000, 18'h2AAAA, 18'h15555, 1'b1, 1'b0, 1'b0);

    $display("[TB] start asserted mid block 2");
    apply_stimulus(18'h3FFFF, 18'h00000, 18'h2AAAA, 18'h15555, 1'b0, 1'b1, 1'b0);

    $display("[TB] abort in block 1 then reload");
    apply_stimulus(18'h2AAAA, 18'h3FFFF, 18'h00000, 18'h00000, 1'b0, 1'b0, 1'b1);
    check_output("abort_queue_drained", q.size(), 0);
    apply_stimulus(18'h1C71C, 18'h2468A, 18'h13579, 18'h3F00F, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset during WRITE");
    @(posedge clk); #1;
    start = 1'b1; cfg_valid = 1'b1; cfg_data = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    check_output("write_cycle_reached", cyc, t0 + 19);
    check_output("pre_rst_wr_en", int'(wr_en), 1);
    #1;
    rst = 1'b1;
    #1;
    check_output("async_rst_wr_en", int'(wr_en), 0);
    check_output("async_rst_bits", int'(bits), 0);
    check_output("async_rst_busy", int'(busy), 0);
    check_output("async_rst_done", int'(done), 0);
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_output("post_rst_cfg_ready", int'(cfg_ready), 0);
    check_output("post_rst_busy", int'(busy), 0);
    check_output("post_rst_wr_en", int'(wr_en), 0);
    repeat (25) @(posedge clk);
    #1;
    check_output("post_rst_idle_busy", int'(busy), 0);
    check_output("final_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
